// File: rtl/tcdm_mem_responder.sv
// TCDM slave memory model: byte-enabled word memory, fixed-latency in-order
// response pipeline, range checking and a saturating error-response counter.
module tcdm_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    input  logic        stall_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_opc_o,
    output logic [7:0]  err_cnt_o
);

    localparam int unsigned AW   = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    logic [31:0]        mem [DEPTH];
    logic [31:0]        offset;
    logic               in_range;
    logic               accept;
    logic [AW-1:0]      idx;
    logic [31:0]        rsp_data;
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] opc_q;
    logic [31:0]        rdata_q [LATENCY];
    logic [7:0]         err_cnt;
    logic               unused_offset_bits;

    // Grant is purely combinational; reset only blocks acceptance via the flops.
    assign gnt_o    = req_i & ~stall_i;
    assign accept   = req_i & ~stall_i;

    // Range check on the offset avoids overflow of BASE_ADDR + 4*DEPTH.
    assign offset   = add_i - BASE_ADDR;
    assign in_range = (add_i >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    always_comb begin
        rsp_data = '0;
        if (in_range && wen_i) begin
            rsp_data = mem[idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && in_range && !wen_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            opc_q   <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= accept;
            opc_q[0]   <= accept & ~in_range;
            rdata_q[0] <= accept ? rsp_data : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                opc_q[i]   <= opc_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign r_valid_o = valid_q[LATENCY-1];
    assign r_opc_o   = valid_q[LATENCY-1] & opc_q[LATENCY-1];
    assign r_rdata_o = valid_q[LATENCY-1] ? rdata_q[LATENCY-1] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt <= '0;
        end else if (r_valid_o && r_opc_o && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Bench for tcdm_mem_responder: three instances (LATENCY 1/3/4) on shared stimulus,
// scoreboard queues per instance checked against a reference memory model.
module tb_tcdm_mem_responder;

    localparam logic [31:0] BASE = 32'h1C00_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_opc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  ropc;
    logic [31:0] rdata [3];
    logic [7:0]  errc [3];

    int          lat [3] = '{1, 3, 4};
    exp_t        sbq [3][$];
    int          merr [3];
    logic [31:0] mm [64];
    int          cyc;
    int          n_tests;
    int          n_fail;

    tcdm_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt[0]),
        .r_valid_o(rvalid[0]), .r_rdata_o(rdata[0]), .r_opc_o(ropc[0]), .err_cnt_o(errc[0])
    );
    tcdm_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt[1]),
        .r_valid_o(rvalid[1]), .r_rdata_o(rdata[1]), .r_opc_o(ropc[1]), .err_cnt_o(errc[1])
    );
    tcdm_mem_responder #(.BASE_ADDR(BASE), .DEPTH(64), .LATENCY(4)) u_l4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .stall_i(stall), .gnt_o(gnt[2]),
        .r_valid_o(rvalid[2]), .r_rdata_o(rdata[2]), .r_opc_o(ropc[2]), .err_cnt_o(errc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd256);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) mm[i] = '0;
    endtask

    task automatic mon(input int n);
        string p;
        exp_t  e;
        p = $sformatf("L%0d", lat[n]);
        if (!rst_n) begin
            sbq[n].delete();
            merr[n] = 0;
            chk({p, " reset r_valid"}, 32'(rvalid[n]), 32'd0);
            chk({p, " reset r_rdata"}, rdata[n], 32'd0);
            chk({p, " reset r_opc"}, 32'(ropc[n]), 32'd0);
            chk({p, " reset err_cnt"}, 32'(errc[n]), 32'd0);
            return;
        end
        chk({p, " err_cnt"}, 32'(errc[n]), 32'(merr[n]));
        if (rvalid[n]) begin
            if (sbq[n].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s spurious response: got r_valid=1 expected no response (cycle %0d)", p, cyc);
            end else begin
                e = sbq[n].pop_front();
                chk({p, " r_rdata"}, rdata[n], e.rdata);
                chk({p, " r_opc"}, 32'(ropc[n]), 32'(e.opc));
                chk({p, " response cycle"}, 32'(cyc), 32'(e.due));
                if (e.opc && merr[n] < 255) merr[n]++;
            end
        end else begin
            chk({p, " idle r_rdata"}, rdata[n], 32'd0);
            chk({p, " idle r_opc"}, 32'(ropc[n]), 32'd0);
            if (sbq[n].size() > 0 && sbq[n][0].due <= cyc) begin
                e = sbq[n].pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s missing response: got r_valid=0 expected response due cycle %0d (cycle %0d)", p, e.due, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) mon(n);
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] er, input logic eo,
                         input int stall_pct);
        bit done;
        done  = 0;
        req   = 1'b1;
        add   = a;
        wen   = w;
        wdata = d;
        be    = b;
        for (int k = 0; k < 64 && !done; k++) begin
            stall = ($urandom_range(99) < stall_pct);
            @(negedge clk);
            for (int n = 0; n < 3; n++)
                chk($sformatf("L%0d gnt", lat[n]), 32'(gnt[n]), 32'(!stall));
            if (!stall) begin
                for (int n = 0; n < 3; n++) begin
                    exp_t e;
                    e.rdata = er;
                    e.opc   = eo;
                    e.due   = cyc + lat[n];
                    sbq[n].push_back(e);
                end
                if (in_rng(a) && !w) begin
                    for (int bb = 0; bb < 4; bb++)
                        if (b[bb]) mm[widx(a)][8*bb +: 8] = d[8*bb +: 8];
                end
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant timeout: got no grant expected grant within 64 cycles");
        end
        req   = 1'b0;
        stall = 1'b0;
    endtask

    task automatic issue_mdl(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] b, input int stall_pct);
        logic [31:0] er;
        er = (in_rng(a) && w) ? mm[widx(a)] : 32'd0;
        issue(a, w, d, b, er, !in_rng(a), stall_pct);
    endtask

    task automatic drain();
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{32'h1C00_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{32'h1C00_0010, 1'b1, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{32'h1C00_0010, 1'b0, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
        tbl[3]  = '{32'h1C00_0012, 1'b1, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0};
        tbl[4]  = '{32'h1C00_0100, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        tbl[5]  = '{32'h1BFF_FFFC, 1'b0, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1};
        tbl[6]  = '{32'h1C00_0010, 1'b1, 32'h0000_0000, 4'hF, 32'hDE22_BE44, 1'b0};
        tbl[7]  = '{32'h1C00_00FC, 1'b0, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
        tbl[8]  = '{32'h1C00_00FC, 1'b1, 32'h0000_0000, 4'h0, 32'hA5A5_A5A5, 1'b0};
        tbl[9]  = '{32'h1C00_0000, 1'b0, 32'hCAFE_F00D, 4'h8, 32'h0000_0000, 1'b0};
        tbl[10] = '{32'h1C00_0000, 1'b1, 32'h0000_0000, 4'hF, 32'hCA00_0000, 1'b0};
        tbl[11] = '{32'h1C00_0004, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};

        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        req = 1'b0; add = '0; wen = 1'b1; wdata = '0; be = '0; stall = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write/read, partial write, out-of-range and boundary words, back to back.
        for (int i = 0; i < 12; i++)
            issue(tbl[i].addr, tbl[i].wen, tbl[i].wdata, tbl[i].be,
                  tbl[i].exp_rdata, tbl[i].exp_opc, 0);
        drain();
        for (int n = 0; n < 3; n++)
            chk($sformatf("L%0d err_cnt after two range errors", lat[n]), 32'(errc[n]), 32'd2);

        // Streaming burst with random contention.
        for (int i = 0; i < 8; i++)
            issue_mdl(BASE + 32'h20 + 32'(4 * i), 1'b0, $urandom, 4'hF, 0);
        for (int i = 0; i < 8; i++)
            issue_mdl(BASE + 32'h20 + 32'(4 * i), 1'b1, 32'd0, 4'hF, 30);
        drain();

        // Reset mid-operation; a request held during reset must not be accepted.
        issue_mdl(BASE, 1'b1, 32'd0, 4'hF, 0);
        issue_mdl(BASE + 32'h4, 1'b1, 32'd0, 4'hF, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_model();
        req = 1'b1; add = BASE; wen = 1'b0; wdata = 32'hFFFF_FFFF; be = 4'hF; stall = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 3; n++)
            chk($sformatf("L%0d gnt during reset", lat[n]), 32'(gnt[n]), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        req = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(BASE, 1'b1, 32'd0, 4'hF, 32'd0, 1'b0, 0);
        drain();

        // Error counter saturation.
        for (int i = 0; i < 260; i++)
            issue(BASE + 32'h100, 1'b1, 32'd0, 4'hF, 32'd0, 1'b1, 0);
        drain();
        for (int n = 0; n < 3; n++)
            chk($sformatf("L%0d err_cnt saturated", lat[n]), 32'(errc[n]), 32'hFF);
        for (int i = 0; i < 3; i++)
            issue(BASE - 32'h4, 1'b1, 32'd0, 4'hF, 32'd0, 1'b1, 20);
        drain();
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("L%0d err_cnt held", lat[n]), 32'(errc[n]), 32'hFF);
            chk($sformatf("L%0d leftover responses", lat[n]), 32'(sbq[n].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
